// File: rtl/sseg_square_animator_pkg.sv
// Shared types, segment constants and glyph helper for the rotating-square display.
package sseg_pkg;

  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    DUAL   = 2'd1,
    FILL   = 2'd2,
    BLANK  = 2'd3
  } anim_mode_t;

  // Segment order {dp,g,f,e,d,c,b,a}, active-low.
  localparam logic [7:0] SEG_UPPER = 8'b1001_1100;
  localparam logic [7:0] SEG_LOWER = 8'b1010_0011;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Combine upper/lower square requests into one digit pattern; dp stays off.
  function automatic logic [7:0] glyph(input logic upper, input logic lower);
    logic [7:0] g;
    case ({upper, lower})
      2'b10:   g = SEG_UPPER;
      2'b01:   g = SEG_LOWER;
      2'b11:   g = SEG_UPPER & SEG_LOWER;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sseg_square_animator_tick_divider.sv
// Modulo-DIV counter that emits a single-cycle tick on its last count.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance (and wrap) only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // A tick suppressed by clear never reaches the consumer.
  assign tick = en && !clr && (cnt_q == LAST);

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sseg_square_animator.sv
// Rotating-square animator: position counter, active-position decode,
// glyph selection and registered an/sseg drive for a multiplexed display.
module sseg_square_animator
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STEP_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 100_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  dir,
  input  anim_mode_t            mode,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            sseg,
  output logic                  step_pulse,
  output logic                  wrap_pulse
);
  localparam int P  = 2 * NUM_DIGITS;
  localparam int PW = $clog2(P);
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] POS_LAST  = PW'(P - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(NUM_DIGITS - 1);

  logic                  step_tick, scan_tick;
  logic [PW-1:0]         pos_q, pos_d;
  logic                  wrap_d;
  logic                  step_pulse_q, wrap_pulse_q;
  logic [SW-1:0]         scan_idx_q, scan_idx_d;
  logic                  upper_sel, lower_sel;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;

  tick_divider #(.DIV(STEP_DIV)) u_step_div (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clr),
    .tick  (step_tick)
  );

  tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (scan_tick)
  );

  // Is loop position p lit for the current position, mode and direction?
  function automatic logic pos_active(input int p, input int cur,
                                      input anim_mode_t m, input logic rev);
    logic act;
    case (m)
      SINGLE:  act = (p == cur);
      DUAL:    act = (p == cur) || (p == ((cur + NUM_DIGITS) % P));
      FILL:    act = rev ? (p >= cur) : (p <= cur);
      default: act = 1'b0;
    endcase
    return act;
  endfunction

  // Position update: clear first, then a step in the direction seen at the tick.
  always_comb begin
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (clr) begin
      pos_d = '0;
    end else if (step_tick) begin
      if (!dir) begin
        if (pos_q == POS_LAST) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end else begin
        if (pos_q == '0) begin
          pos_d  = POS_LAST;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - PW'(1);
        end
      end
    end
  end

  // Scan slot advances on every scan tick, wrapping at the last digit.
  always_comb begin
    scan_idx_d = scan_idx_q;
    if (scan_tick) begin
      scan_idx_d = (scan_idx_q == SCAN_LAST) ? '0 : scan_idx_q + SW'(1);
    end
  end

  // Decode the digit under scan: upper square is position d, lower is P-1-d.
  always_comb begin
    upper_sel = pos_active(int'(scan_idx_q), int'(pos_q), mode, dir);
    lower_sel = pos_active(P - 1 - int'(scan_idx_q), int'(pos_q), mode, dir);
    an_d      = ~(NUM_DIGITS'(1) << scan_idx_q);
    sseg_d    = glyph(upper_sel, lower_sel);
  end

  // Animation state and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q        <= '0;
      scan_idx_q   <= '0;
      step_pulse_q <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      scan_idx_q   <= scan_idx_d;
      step_pulse_q <= step_tick;
      wrap_pulse_q <= step_tick && wrap_d;
    end
  end

  // Display pin registers, one cycle behind the decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q   <= '1;
      sseg_q <= SEG_BLANK;
    end else begin
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign step_pulse = step_pulse_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule
